// File: rtl/div_multicycle_pkg.sv
// Shared constants for the iterative divider: FSM state width and encodings.
package div_multicycle_pkg;

   localparam int DIV_STATE_W = 2;

   typedef enum logic [DIV_STATE_W-1:0] {
      DIV_IDLE = 2'd0,
      DIV_ZERO = 2'd1,
      DIV_ON   = 2'd2,
      DIV_END  = 2'd3
   } div_state_e;

endpackage

// File: rtl/div_multicycle_cond_neg.sv
// Conditional two's-complement: passes the value through, or negates it when neg_i is set.
module div_multicycle_cond_neg #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] val_i,
   input  logic             neg_i,
   output logic [WIDTH-1:0] val_o
);

   assign val_o = neg_i ? (~val_i + 1'b1) : val_i;

endmodule

// File: rtl/div_multicycle.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, stalls EX while busy,
// presents {HI, LO} for a single cycle on ready_o.
//
// state    | meaning
// DIV_IDLE | waiting for start; operands latched on the way to DIV_ON
// DIV_ZERO | divisor was zero; result forced to 0
// DIV_ON   | one shift/subtract step per cycle, WIDTH steps
// DIV_END  | result valid, ready_o high for this cycle only
module div_multicycle
   import div_multicycle_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               stall_o
);

   localparam int CNT_W = $clog2(WIDTH);

   div_state_e           state_q,  state_d;
   logic [CNT_W-1:0]     cnt_q,    cnt_d;
   logic [WIDTH-1:0]     dvd_q,    dvd_d;
   logic [WIDTH-1:0]     dvs_q,    dvs_d;
   logic [WIDTH-1:0]     rem_q,    rem_d;
   logic                 neg_quo_q, neg_quo_d;
   logic                 neg_rem_q, neg_rem_d;
   logic [2*WIDTH-1:0]   result_q, result_d;

   logic                 sign_a, sign_b;
   logic [WIDTH-1:0]     a_abs, b_abs;
   logic [WIDTH:0]       rem_sh;
   logic                 q_bit;
   logic [WIDTH-1:0]     rem_nxt, quo_nxt;
   logic [WIDTH-1:0]     rem_fix, quo_fix;

   assign sign_a = signed_div_i & a_i[WIDTH-1];
   assign sign_b = signed_div_i & b_i[WIDTH-1];

   div_multicycle_cond_neg #(.WIDTH(WIDTH)) u_abs_a (.val_i(a_i),     .neg_i(sign_a),    .val_o(a_abs));
   div_multicycle_cond_neg #(.WIDTH(WIDTH)) u_abs_b (.val_i(b_i),     .neg_i(sign_b),    .val_o(b_abs));
   div_multicycle_cond_neg #(.WIDTH(WIDTH)) u_fix_q (.val_i(quo_nxt), .neg_i(neg_quo_q), .val_o(quo_fix));
   div_multicycle_cond_neg #(.WIDTH(WIDTH)) u_fix_r (.val_i(rem_nxt), .neg_i(neg_rem_q), .val_o(rem_fix));

   // Quotient bits shift into the dividend register as dividend bits shift out.
   assign rem_sh  = {rem_q, dvd_q[WIDTH-1]};
   assign q_bit   = (rem_sh >= {1'b0, dvs_q});
   assign rem_nxt = q_bit ? (rem_sh[WIDTH-1:0] - dvs_q) : rem_sh[WIDTH-1:0];
   assign quo_nxt = {dvd_q[WIDTH-2:0], q_bit};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      rem_d     = rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      case (state_q)
         DIV_IDLE: begin
            if (start_i && !annul_i) begin
               if (b_i == '0) begin
                  state_d = DIV_ZERO;
               end else begin
                  state_d   = DIV_ON;
                  dvd_d     = a_abs;
                  dvs_d     = b_abs;
                  rem_d     = '0;
                  cnt_d     = '0;
                  neg_quo_d = sign_a ^ sign_b;
                  neg_rem_d = sign_a;
               end
            end
         end
         DIV_ZERO: begin
            if (annul_i) begin
               state_d = DIV_IDLE;
            end else begin
               state_d  = DIV_END;
               result_d = '0;
            end
         end
         DIV_ON: begin
            if (annul_i) begin
               state_d = DIV_IDLE;
            end else begin
               dvd_d = quo_nxt;
               rem_d = rem_nxt;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH-1)) begin
                  state_d  = DIV_END;
                  result_d = {rem_fix, quo_fix};
               end
            end
         end
         DIV_END:  state_d = DIV_IDLE;
         default:  state_d = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= DIV_IDLE;
         cnt_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         rem_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         rem_q     <= rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
      end
   end

   assign result_o = result_q;
   assign ready_o  = (state_q == DIV_END);
   // Pipeline is released in DIV_END so it advances on the same cycle the result is captured.
   assign stall_o  = start_i & ~annul_i & ~rst_i & (state_q != DIV_END);

endmodule
